// File: rtl/board_pkg.sv
// Shared types, default board geometry and the index-to-row/column helper
// used by the cell cursor and its pixel renderer.
package board_pkg;

    typedef enum logic [1:0] {
        SEEK_FWD = 2'd0,
        SEEK_BWD = 2'd1,
        HOLD     = 2'd2,
        FULL     = 2'd3
    } cursor_state_t;

    localparam int DEF_N       = 3;
    localparam int DEF_CELL_PX = 5;
    localparam int DEF_DISP    = 16;

    // Packs {row, col} of a row-major index into two bytes; constant-folded into a ROM.
    function automatic logic [15:0] cell_rc(input int idx, input int n);
        cell_rc = {8'(idx / n), 8'(idx % n)};
    endfunction

endpackage

// File: rtl/cell_cursor_if.sv
// Board-side bundle of the cell cursor: occupancy and button pulses in,
// cursor position, status flags and the green pixel layer out.
interface cell_cursor_if #(
    parameter int N    = 3,
    parameter int DISP = 16
);
    localparam int NC = N * N;
    localparam int CW = $clog2(NC);

    logic [NC-1:0]                occupied;
    logic                         next;
    logic                         prev;
    logic [CW-1:0]                cur_cell;
    logic                         cur_valid;
    logic                         full;
    logic [DISP-1:0][DISP-1:0]    GrnPixels;

    modport master (
        output occupied, next, prev,
        input  cur_cell, cur_valid, full, GrnPixels
    );

    modport slave (
        input  occupied, next, prev,
        output cur_cell, cur_valid, full, GrnPixels
    );

endinterface

// File: rtl/cell_highlight_render.sv
// Combinational green layer: grid lines across the line span plus a 2x2 marker
// inside the selected cell when show_marker is set.
module cell_highlight_render #(
    parameter int N       = 3,
    parameter int CELL_PX = 5,
    parameter int DISP    = 16,
    parameter int RW      = 2
) (
    input  logic                      show_marker,
    input  logic [RW-1:0]             row,
    input  logic [RW-1:0]             col,
    output logic [DISP-1:0][DISP-1:0] pixels
);
    localparam int SPAN = (N - 1) * CELL_PX;
    localparam int EXT  = N * CELL_PX;

    genvar gi, gx;
    generate
        for (gi = 0; gi < DISP; gi++) begin : g_row
            for (gx = 0; gx < DISP; gx++) begin : g_col
                // Lines run only from the origin to the last interior line.
                localparam bit IN_SPAN = (gx <= SPAN) && (gi <= SPAN);
                localparam bit VLINE   = (gx > 0) && (gx % CELL_PX == 0) && (gx < EXT);
                localparam bit HLINE   = (gi > 0) && (gi % CELL_PX == 0) && (gi < EXT);
                localparam bit MARK_Y  = (gi < EXT) && ((gi % CELL_PX == 2) || (gi % CELL_PX == 3));
                localparam bit MARK_X  = (gx < EXT) && ((gx % CELL_PX == 2) || (gx % CELL_PX == 3));
                localparam int CELL_R  = gi / CELL_PX;
                localparam int CELL_C  = gx / CELL_PX;

                assign pixels[gi][DISP-1-gx] =
                    (IN_SPAN && (VLINE || HLINE)) ||
                    (show_marker && MARK_Y && MARK_X &&
                     (row == RW'(CELL_R)) && (col == RW'(CELL_C)));
            end
        end
    endgenerate

endmodule

// File: rtl/cell_cursor.sv
// NxN cell-selection cursor: seeks the next free cell in either direction with
// wrap-around, parks in FULL when the board is full, and drives the green layer.
module cell_cursor
    import board_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int CELL_PX = DEF_CELL_PX,
    parameter int DISP    = DEF_DISP
) (
    input  logic          clk,
    input  logic          reset,
    cell_cursor_if.slave  bus
);
    localparam int NC    = N * N;
    localparam int CW    = $clog2(NC);
    localparam int OCC_W = 2 ** CW;
    localparam int RW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(NC - 1);

    cursor_state_t             state_q, state_d;
    logic [CW-1:0]             cur_q, cur_d;
    logic                      valid_q, full_q;
    logic [DISP-1:0][DISP-1:0] pix_q, pix_d;

    logic [OCC_W-1:0] occ_ext;
    logic [CW-1:0]    cur_inc, cur_dec;
    logic [RW-1:0]    row_rom [OCC_W];
    logic [RW-1:0]    col_rom [OCC_W];

    assign occ_ext = OCC_W'(bus.occupied);
    assign cur_inc = (cur_q == LAST)  ? '0   : cur_q + 1'b1;
    assign cur_dec = (cur_q == '0)    ? LAST : cur_q - 1'b1;

    // Constant-divisor row/column lookup, padded to a power-of-two depth.
    genvar gi;
    generate
        for (gi = 0; gi < OCC_W; gi++) begin : g_rc_rom
            if (gi < NC) begin : g_cell
                localparam logic [15:0] RC = cell_rc(gi, N);
                assign row_rom[gi] = RW'(RC[15:8]);
                assign col_rom[gi] = RW'(RC[7:0]);
            end else begin : g_pad
                assign row_rom[gi] = '0;
                assign col_rom[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        if (&bus.occupied) begin
            state_d = FULL;
        end else begin
            case (state_q)
                FULL: begin
                    cur_d   = LAST;
                    state_d = SEEK_FWD;
                end
                SEEK_FWD: begin
                    cur_d = cur_inc;
                    if (!occ_ext[cur_inc]) state_d = HOLD;
                end
                SEEK_BWD: begin
                    cur_d = cur_dec;
                    if (!occ_ext[cur_dec]) state_d = HOLD;
                end
                HOLD: begin
                    if (occ_ext[cur_q])               state_d = SEEK_FWD;
                    else if (bus.next && !bus.prev)   state_d = SEEK_FWD;
                    else if (bus.prev && !bus.next)   state_d = SEEK_BWD;
                end
                default: state_d = SEEK_FWD;
            endcase
        end
    end

    cell_highlight_render #(
        .N       (N),
        .CELL_PX (CELL_PX),
        .DISP    (DISP),
        .RW      (RW)
    ) u_render (
        .show_marker (state_q == HOLD),
        .row         (row_rom[cur_q]),
        .col         (col_rom[cur_q]),
        .pixels      (pix_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEEK_FWD;
            cur_q   <= LAST;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            valid_q <= (state_d == HOLD);
            full_q  <= (state_d == FULL);
            pix_q   <= pix_d;
        end
    end

    assign bus.cur_cell  = cur_q;
    assign bus.cur_valid = valid_q;
    assign bus.full      = full_q;
    assign bus.GrnPixels = pix_q;

endmodule

// File: tb/tb_cell_cursor.sv
// Directed bench for cell_cursor: a 3x3/5px build and a 4x4/4px build driven
// from shared clock and reset.
module tb_cell_cursor;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cell_cursor_if #(.N(3), .DISP(16)) bus3 ();
    cell_cursor_if #(.N(4), .DISP(16)) bus4 ();

    cell_cursor #(.N(3), .CELL_PX(5), .DISP(16)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    cell_cursor #(.N(4), .CELL_PX(4), .DISP(16)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press_next3();
        bus3.next = 1'b1;
        tick();
        bus3.next = 1'b0;
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        bus3.occupied = '0;
        bus3.next     = 1'b0;
        bus3.prev     = 1'b0;
        bus4.occupied = '0;
        bus4.next     = 1'b0;
        bus4.prev     = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_cur",   32'(bus3.cur_cell),  32'd8);
        check("rst_valid", 32'(bus3.cur_valid), 32'd0);
        check("rst_full",  32'(bus3.full),      32'd0);
        check("rst_row5",  32'(bus3.GrnPixels[5]), 32'h0);

        // First seek step lands on cell 0
        reset = 1'b0;
        tick();
        check("t1_cur",   32'(bus3.cur_cell),  32'd0);
        check("t1_valid", 32'(bus3.cur_valid), 32'd1);
        check("t1_row2_grid", 32'(bus3.GrnPixels[2]), 32'h0420);
        tick();
        check("t1_row2_mark", 32'(bus3.GrnPixels[2]), 32'b0011010000100000);
        check("t1_row3_mark", 32'(bus3.GrnPixels[3]), 32'b0011010000100000);
        check("t1_row5_line", 32'(bus3.GrnPixels[5]), 32'hFFE0);

        // Forward seek skipping 0,1 then backward wrap 2->1->0->8
        bus3.occupied = 9'b000010011;
        bus3.next     = 1'b1;
        tick();
        bus3.next = 1'b0;
        check("t2_leave_valid", 32'(bus3.cur_valid), 32'd0);
        tick();
        check("t2_seek_cur1", 32'(bus3.cur_cell), 32'd1);
        tick();
        check("t2_hold_cur", 32'(bus3.cur_cell),  32'd2);
        check("t2_hold_vld", 32'(bus3.cur_valid), 32'd1);
        bus3.prev = 1'b1;
        tick();
        bus3.prev = 1'b0;
        tick();
        check("t2_bwd_cur1", 32'(bus3.cur_cell), 32'd1);
        tick();
        check("t2_bwd_cur0", 32'(bus3.cur_cell), 32'd0);
        tick();
        check("t2_wrap_cur", 32'(bus3.cur_cell),  32'd8);
        check("t2_wrap_vld", 32'(bus3.cur_valid), 32'd1);

        // Walk to cell 4, then occupy it and watch the auto-advance
        bus3.occupied = '0;
        press_next3();
        check("t3_wrap0", 32'(bus3.cur_cell), 32'd0);
        for (int i = 1; i <= 4; i++) press_next3();
        check("t3_at4", 32'(bus3.cur_cell), 32'd4);
        bus3.occupied = 9'h010;
        tick();
        check("t3_adv_vld0", 32'(bus3.cur_valid), 32'd0);
        tick();
        check("t3_adv_cur", 32'(bus3.cur_cell),  32'd5);
        check("t3_adv_vld", 32'(bus3.cur_valid), 32'd1);
        bus3.next = 1'b1;
        bus3.prev = 1'b1;
        tick();
        bus3.next = 1'b0;
        bus3.prev = 1'b0;
        check("t3_both_cur", 32'(bus3.cur_cell),  32'd5);
        check("t3_both_vld", 32'(bus3.cur_valid), 32'd1);

        // Full board, then free cell 6
        bus3.occupied = 9'h1FF;
        tick();
        check("t4_full",  32'(bus3.full),      32'd1);
        check("t4_vld",   32'(bus3.cur_valid), 32'd0);
        tick();
        check("t4_row2",  32'(bus3.GrnPixels[2]),  32'h0420);
        check("t4_row5",  32'(bus3.GrnPixels[5]),  32'hFFE0);
        check("t4_row10", 32'(bus3.GrnPixels[10]), 32'hFFE0);
        check("t4_row15", 32'(bus3.GrnPixels[15]), 32'h0);
        bus3.occupied = 9'h1BF;
        for (int i = 0; i < 20 && !bus3.cur_valid; i++) tick();
        check("t4_free_vld",  32'(bus3.cur_valid), 32'd1);
        check("t4_free_cur",  32'(bus3.cur_cell),  32'd6);
        check("t4_free_full", 32'(bus3.full),      32'd0);

        // Reset in the middle of a seek
        bus3.occupied = 9'h0FE;
        tick();
        tick();
        check("t5_midseek", 32'(bus3.cur_valid), 32'd0);
        reset = 1'b1;
        tick();
        check("t5_rst_cur",  32'(bus3.cur_cell),  32'd8);
        check("t5_rst_vld",  32'(bus3.cur_valid), 32'd0);
        check("t5_rst_pix",  32'(bus3.GrnPixels[5]), 32'h0);
        reset = 1'b0;
        tick();
        check("t5_resume_cur", 32'(bus3.cur_cell),  32'd0);
        check("t5_resume_vld", 32'(bus3.cur_valid), 32'd1);

        // 4x4 build: sweep all 16 cells and wrap
        check("t6_start", 32'(bus4.cur_cell), 32'd0);
        for (int i = 1; i <= 15; i++) begin
            bus4.next = 1'b1;
            tick();
            bus4.next = 1'b0;
            tick();
            check($sformatf("t6_step%0d", i), 32'(bus4.cur_cell), 32'(i));
        end
        tick();
        check("t6_row14_mark", 32'(bus4.GrnPixels[14][1:0]), 32'd3);
        check("t6_row15_mark", 32'(bus4.GrnPixels[15][1:0]), 32'd3);
        check("t6_row13_none", 32'(bus4.GrnPixels[13][1:0]), 32'd0);
        bus4.next = 1'b1;
        tick();
        bus4.next = 1'b0;
        tick();
        check("t6_wrap_cur", 32'(bus4.cur_cell),  32'd0);
        check("t6_wrap_vld", 32'(bus4.cur_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
